// File: rtl/ptrain_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ptrain_pkg : shared state enum, output encodings, saturating add |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ptrain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_CALC  = 3'd2,
    ST_UPD   = 3'd3,
    ST_EPOCH = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [1:0] POS = 2'b01;
  localparam logic [1:0] NEG = 2'b11;

  // Adds two sign-extended operands and clamps to the signed ww-bit range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned        ww);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (ww - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (ww - 1));
    if (s > hi) begin
      return hi[31:0];
    end else if (s < lo) begin
      return lo[31:0];
    end
    return s[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ptrain_mac.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ptrain_mac : combinational sum-of-products plus bias, sign out   |
// | PTRAIN_SAT_EN selects a saturating sum. Rev 1.0                  |
// +------------------------------------------------------------------+
module ptrain_mac
  import ptrain_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int DW   = 7,
  parameter int WW   = 14,
  parameter int FRAC = 4
) (
  input  logic [N_IN*DW-1:0] x_i,
  input  logic [N_IN*WW-1:0] w_i,
  input  logic [WW-1:0]      b_i,
  output logic               neg_o
);

  logic signed [2*WW-1:0] prod;
  logic signed [WW-1:0]   term;
  logic signed [WW-1:0]   acc;

  always_comb begin
    prod = '0;
    term = '0;
    acc  = '0;
    for (int i = 0; i < N_IN; i++) begin
      prod = $signed({{(2*WW-DW){x_i[i*DW+DW-1]}}, x_i[i*DW +: DW]}) *
             $signed({{WW{w_i[i*WW+WW-1]}}, w_i[i*WW +: WW]});
      // Floor-shifted product, then only the low WW bits contribute.
      term = WW'(prod >>> FRAC);
`ifdef PTRAIN_SAT_EN
      acc = WW'(sat_add(32'(acc), 32'(term), WW));
`else
      acc = acc + term;
`endif
    end
`ifdef PTRAIN_SAT_EN
    acc = WW'(sat_add(32'(acc), 32'($signed(b_i)), WW));
`else
    acc = acc + b_i;
`endif
  end

  assign neg_o = acc[WW-1];

endmodule
`default_nettype wire

// File: rtl/perceptron_trainer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | perceptron_trainer : streamed single-layer perceptron training   |
// | PTRAIN_SAT_EN makes sum and updates saturate. Rev 1.0            |
// +------------------------------------------------------------------+
module perceptron_trainer
  import ptrain_pkg::*;
#(
  parameter int N_IN      = 2,
  parameter int DW        = 7,
  parameter int WW        = 14,
  parameter int FRAC      = 4,
  parameter int ALPHA     = 3,
  parameter int MAX_EPOCH = 200,
  parameter int EW        = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [N_IN*DW-1:0] s_x,
  input  logic [1:0]         s_t,
  input  logic               s_last,
  output logic [1:0]         y,
  output logic [N_IN*WW-1:0] w_out,
  output logic [WW-1:0]      b_out,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [EW-1:0]      epoch_cnt,
  output logic [EW-1:0]      err_cnt
);

  state_e               state_q;
  logic [N_IN*DW-1:0]   x_q;
  logic                 t_neg_q;
  logic                 last_q;
  logic [N_IN*WW-1:0]   w_q, w_d;
  logic [WW-1:0]        b_q, b_d;
  logic [1:0]           y_q;
  logic [EW-1:0]        epoch_q, err_q;
  logic                 done_q, conv_q;
  logic                 neg_w;
  logic signed [31:0]   xs, dlt, bdl;

  ptrain_mac #(.N_IN(N_IN), .DW(DW), .WW(WW), .FRAC(FRAC)) u_mac (
    .x_i   (x_q),
    .w_i   (w_q),
    .b_i   (b_q),
    .neg_o (neg_w)
  );

  // Candidate weights/bias if the current sample was misclassified.
  always_comb begin
    w_d = w_q;
    b_d = b_q;
    xs  = '0;
    dlt = '0;
    for (int i = 0; i < N_IN; i++) begin
      xs  = 32'($signed(x_q[i*DW +: DW]));
      dlt = xs * ALPHA;
      if (t_neg_q) dlt = -dlt;
`ifdef PTRAIN_SAT_EN
      w_d[i*WW +: WW] = WW'(sat_add(32'($signed(w_q[i*WW +: WW])), dlt, WW));
`else
      w_d[i*WW +: WW] = w_q[i*WW +: WW] + WW'(dlt);
`endif
    end
    bdl = 32'(ALPHA);
    if (t_neg_q) bdl = -bdl;
`ifdef PTRAIN_SAT_EN
    b_d = WW'(sat_add(32'($signed(b_q)), bdl, WW));
`else
    b_d = b_q + WW'(bdl);
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      t_neg_q <= 1'b0;
      last_q  <= 1'b0;
      w_q     <= '0;
      b_q     <= '0;
      y_q     <= POS;
      epoch_q <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_q     <= '0;
            b_q     <= '0;
            epoch_q <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (s_valid) begin
            x_q     <= s_x;
            t_neg_q <= s_t[1];
            last_q  <= s_last;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          y_q     <= neg_w ? NEG : POS;
          state_q <= ST_UPD;
        end
        ST_UPD: begin
          if (y_q[1] != t_neg_q) begin
            w_q <= w_d;
            b_q <= b_d;
            if (err_q != '1) err_q <= err_q + 1'b1;
          end
          state_q <= last_q ? ST_EPOCH : ST_WAIT;
        end
        ST_EPOCH: begin
          epoch_q <= epoch_q + 1'b1;
          if (err_q == '0) begin
            conv_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (epoch_q + 1'b1 == EW'(MAX_EPOCH)) begin
            conv_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            err_q   <= '0;
            state_q <= ST_WAIT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready   = (state_q == ST_WAIT);
  assign busy      = (state_q == ST_WAIT) || (state_q == ST_CALC) ||
                     (state_q == ST_UPD)  || (state_q == ST_EPOCH);
  assign y         = y_q;
  assign w_out     = w_q;
  assign b_out     = b_q;
  assign done      = done_q;
  assign converged = conv_q;
  assign epoch_cnt = epoch_q;
  assign err_cnt   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_perceptron_trainer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_perceptron_trainer : directed bench with reference model      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_perceptron_trainer;

  localparam int N    = 2;
  localparam int DW   = 7;
  localparam int FR   = 4;
  localparam int EW   = 8;
  localparam int WW_A = 14;
  localparam int WW_C = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  logic            start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic            s_valid = 1'b0;
  logic [N*DW-1:0] s_x = '0;
  logic [1:0]      s_t = 2'b01;
  logic            s_last = 1'b0;

  logic              rdy_a, busy_a, done_a, conv_a;
  logic [1:0]        y_a;
  logic [N*WW_A-1:0] w_a;
  logic [WW_A-1:0]   b_a;
  logic [EW-1:0]     ep_a, er_a;
  logic              rdy_b, busy_b, done_b, conv_b;
  logic [1:0]        y_b;
  logic [N*WW_A-1:0] w_b;
  logic [WW_A-1:0]   b_b;
  logic [EW-1:0]     ep_b, er_b;
  logic              rdy_c, busy_c, done_c, conv_c;
  logic [1:0]        y_c;
  logic [N*WW_C-1:0] w_c;
  logic [WW_C-1:0]   b_c;
  logic [EW-1:0]     ep_c, er_c;

  perceptron_trainer #(.N_IN(N), .DW(DW), .WW(WW_A), .FRAC(FR), .ALPHA(3),
                       .MAX_EPOCH(200), .EW(EW)) u_dut_a (
    .Clk(Clk), .Rst(Rst), .start(start_a), .s_valid(s_valid), .s_ready(rdy_a),
    .s_x(s_x), .s_t(s_t), .s_last(s_last), .y(y_a), .w_out(w_a), .b_out(b_a),
    .busy(busy_a), .done(done_a), .converged(conv_a), .epoch_cnt(ep_a), .err_cnt(er_a));

  perceptron_trainer #(.N_IN(N), .DW(DW), .WW(WW_A), .FRAC(FR), .ALPHA(3),
                       .MAX_EPOCH(4), .EW(EW)) u_dut_b (
    .Clk(Clk), .Rst(Rst), .start(start_b), .s_valid(s_valid), .s_ready(rdy_b),
    .s_x(s_x), .s_t(s_t), .s_last(s_last), .y(y_b), .w_out(w_b), .b_out(b_b),
    .busy(busy_b), .done(done_b), .converged(conv_b), .epoch_cnt(ep_b), .err_cnt(er_b));

  perceptron_trainer #(.N_IN(N), .DW(DW), .WW(WW_C), .FRAC(FR), .ALPHA(63),
                       .MAX_EPOCH(3), .EW(EW)) u_dut_c (
    .Clk(Clk), .Rst(Rst), .start(start_c), .s_valid(s_valid), .s_ready(rdy_c),
    .s_x(s_x), .s_t(s_t), .s_last(s_last), .y(y_c), .w_out(w_c), .b_out(b_c),
    .busy(busy_c), .done(done_c), .converged(conv_c), .epoch_cnt(ep_c), .err_cnt(er_c));

  int n_chk  = 0;
  int n_fail = 0;
  int sel    = 0;

  // Reference model state for the selected instance
  int     m_ww, m_alpha, m_max;
  longint mw [N];
  longint mb;
  int     merr, mepoch;
  bit     mdone, mconv;

  typedef struct {
    logic [1:0] y;
    longint     w0, w1, b;
    int         err;
  } exp_t;
  exp_t sb[$];

  longint smp_x0 [4];
  longint smp_x1 [4];
  bit     smp_tn [4];
  int     n_smp;

  function automatic longint dut_w(int i);
    case (sel)
      0:       return longint'($signed(w_a[i*WW_A +: WW_A]));
      1:       return longint'($signed(w_b[i*WW_A +: WW_A]));
      default: return longint'($signed(w_c[i*WW_C +: WW_C]));
    endcase
  endfunction
  function automatic longint dut_b();
    case (sel)
      0:       return longint'($signed(b_a));
      1:       return longint'($signed(b_b));
      default: return longint'($signed(b_c));
    endcase
  endfunction
  function automatic longint dut_y();
    case (sel) 0: return longint'(y_a); 1: return longint'(y_b); default: return longint'(y_c); endcase
  endfunction
  function automatic longint dut_rdy();
    case (sel) 0: return longint'(rdy_a); 1: return longint'(rdy_b); default: return longint'(rdy_c); endcase
  endfunction
  function automatic longint dut_busy();
    case (sel) 0: return longint'(busy_a); 1: return longint'(busy_b); default: return longint'(busy_c); endcase
  endfunction
  function automatic longint dut_done();
    case (sel) 0: return longint'(done_a); 1: return longint'(done_b); default: return longint'(done_c); endcase
  endfunction
  function automatic longint dut_conv();
    case (sel) 0: return longint'(conv_a); 1: return longint'(conv_b); default: return longint'(conv_c); endcase
  endfunction
  function automatic longint dut_ep();
    case (sel) 0: return longint'(ep_a); 1: return longint'(ep_b); default: return longint'(ep_c); endcase
  endfunction
  function automatic longint dut_err();
    case (sel) 0: return longint'(er_a); 1: return longint'(er_b); default: return longint'(er_c); endcase
  endfunction

  task automatic check(input string tag, input longint obs, input longint expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint wrapv(longint v, int ww);
    longint m, r;
    m = 64'sd1 <<< ww;
    r = v % m;
    if (r < 0) r = r + m;
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic longint normv(longint v, int ww);
    longint half;
    half = 64'sd1 <<< (ww - 1);
`ifdef PTRAIN_SAT_EN
    if (v > half - 1) return half - 1;
    if (v < -half) return -half;
    return v;
`else
    return wrapv(v, ww);
`endif
  endfunction

  function automatic bit model_neg(longint x0, longint x1);
    longint acc, p;
    longint xv [N];
    xv[0] = x0;
    xv[1] = x1;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      p   = xv[i] * mw[i];
      acc = normv(acc + wrapv(p >>> FR, m_ww), m_ww);
    end
    acc = normv(acc + mb, m_ww);
    return acc < 0;
  endfunction

  task automatic set_sel(input int s);
    sel = s;
    case (s)
      0:       begin m_ww = WW_A; m_alpha = 3;  m_max = 200; end
      1:       begin m_ww = WW_A; m_alpha = 3;  m_max = 4;   end
      default: begin m_ww = WW_C; m_alpha = 63; m_max = 3;   end
    endcase
  endtask

  task automatic model_clear();
    mw[0] = 0; mw[1] = 0; mb = 0; merr = 0; mepoch = 0; mdone = 0; mconv = 0;
    sb.delete();
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    case (sel) 0: start_a = 1'b1; 1: start_b = 1'b1; default: start_c = 1'b1; endcase
    @(negedge Clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    model_clear();
    check("busy_after_start", dut_busy(), 1);
    check("done_after_start", dut_done(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_y"},     dut_y(), 1);
    check({tag, "_w0"},    dut_w(0), 0);
    check({tag, "_w1"},    dut_w(1), 0);
    check({tag, "_b"},     dut_b(), 0);
    check({tag, "_done"},  dut_done(), 0);
    check({tag, "_conv"},  dut_conv(), 0);
    check({tag, "_busy"},  dut_busy(), 0);
    check({tag, "_ready"}, dut_rdy(), 0);
    check({tag, "_epoch"}, dut_ep(), 0);
    check({tag, "_err"},   dut_err(), 0);
  endtask

  task automatic drive_sample(input longint x0, input longint x1, input bit tneg,
                              input bit last, input bit abort);
    exp_t   e;
    bit     yneg, got;
    longint sg;
    yneg = model_neg(x0, x1);
    e.y  = yneg ? 2'b11 : 2'b01;
    if (yneg != tneg) begin
      sg    = tneg ? -1 : 1;
      mw[0] = normv(mw[0] + sg * m_alpha * x0, m_ww);
      mw[1] = normv(mw[1] + sg * m_alpha * x1, m_ww);
      mb    = normv(mb + sg * m_alpha, m_ww);
      if (merr < 255) merr++;
    end
    e.w0 = mw[0]; e.w1 = mw[1]; e.b = mb; e.err = merr;
    sb.push_back(e);

    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (dut_rdy() == 1) begin
        got = 1'b1;
        break;
      end
    end
    check("ready_seen", longint'(got), 1);
    if (!got) begin
      void'(sb.pop_back());
      return;
    end
    s_valid = 1'b1;
    s_x     = {x1[DW-1:0], x0[DW-1:0]};
    s_t     = tneg ? 2'b11 : 2'b01;
    s_last  = last;
    @(posedge Clk);
    #1;
    s_valid = 1'b0;
    check("ready_low_in_calc", dut_rdy(), 0);
    if (abort) begin
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      model_clear();
      return;
    end
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check("y", dut_y(), longint'(e.y));
    @(posedge Clk);
    #1;
    check("w0", dut_w(0), e.w0);
    check("w1", dut_w(1), e.w1);
    check("b", dut_b(), e.b);
    check("err_cnt", dut_err(), longint'(e.err));
  endtask

  task automatic epoch_end();
    mepoch++;
    if (merr == 0) begin
      mdone = 1; mconv = 1;
    end else if (mepoch == m_max) begin
      mdone = 1; mconv = 0;
    end else begin
      merr = 0;
    end
    @(posedge Clk);
    #1;
    check("epoch_cnt", dut_ep(), longint'(mepoch));
    check("done", dut_done(), longint'(mdone));
    check("converged", dut_conv(), longint'(mconv));
    check("busy", dut_busy(), longint'(!mdone));
    check("epoch_err_cnt", dut_err(), longint'(merr));
  endtask

  task automatic train();
    pulse_start();
    for (int ep = 0; ep < 20; ep++) begin
      for (int j = 0; j < n_smp; j++) begin
        drive_sample(smp_x0[j], smp_x1[j], smp_tn[j], (j == n_smp - 1), 1'b0);
      end
      epoch_end();
      if (mdone) break;
    end
    check("train_terminated", longint'(mdone), 1);
  endtask

  initial begin
    // Reset state of every instance, then idle s_valid pulses
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      set_sel(s);
      check_reset_outputs("reset");
    end
    set_sel(0);
    s_valid = 1'b1;
    repeat (3) @(negedge Clk);
    s_valid = 1'b0;
    check("idle_ready", dut_rdy(), 0);
    check("idle_busy", dut_busy(), 0);
    check("idle_y", dut_y(), 1);

    // Single correctly classified sample converges in one epoch
    set_sel(0);
    n_smp = 1;
    smp_x0[0] = 1; smp_x1[0] = 1; smp_tn[0] = 1'b0;
    train();
    check("t2_conv", dut_conv(), 1);
    check("t2_epoch", dut_ep(), 1);
    check("t2_w0", dut_w(0), 0);

    // One update then convergence
    n_smp = 1;
    smp_x0[0] = 5; smp_x1[0] = 0; smp_tn[0] = 1'b1;
    train();
    check("t3_w0", dut_w(0), -15);
    check("t3_b", dut_b(), -3);
    check("t3_epoch", dut_ep(), 2);
    check("t3_conv", dut_conv(), 1);

    // Contradictory pair hits the epoch limit
    set_sel(1);
    n_smp = 2;
    smp_x0[0] = 1; smp_x1[0] = 0; smp_tn[0] = 1'b0;
    smp_x0[1] = 1; smp_x1[1] = 0; smp_tn[1] = 1'b1;
    train();
    check("t4_done", dut_done(), 1);
    check("t4_conv", dut_conv(), 0);
    check("t4_epoch", dut_ep(), 4);

    // Reset during CALC of epoch 2, then retrain from zero
    set_sel(0);
    pulse_start();
    drive_sample(1, 0, 1'b0, 1'b0, 1'b0);
    drive_sample(1, 0, 1'b1, 1'b1, 1'b0);
    epoch_end();
    drive_sample(1, 0, 1'b0, 1'b0, 1'b1);
    check_reset_outputs("abort");
    n_smp = 1;
    smp_x0[0] = 5; smp_x1[0] = 0; smp_tn[0] = 1'b1;
    train();
    check("t5_w0", dut_w(0), -15);
    check("t5_epoch", dut_ep(), 2);

    // Large updates on a narrow weight: clamp or wrap
    set_sel(2);
    n_smp = 2;
    smp_x0[0] = 0;  smp_x1[0] = 0; smp_tn[0] = 1'b1;
    smp_x0[1] = 63; smp_x1[1] = 0; smp_tn[1] = 1'b0;
    train();
`ifdef PTRAIN_SAT_EN
    check("t6_w0_clamp", dut_w(0), 127);
`else
    check("t6_w0_wrap", dut_w(0), -125);
`endif
    check("t6_epoch", dut_ep(), 3);
    check("t6_conv", dut_conv(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
Parametrised single-layer perceptron training engine for N_IN signed inputs with a streamed training set.
- Accepts samples over a valid/ready handshake.
- Computes the sign output, applies the perceptron update rule on mismatch, and repeats epochs.
- Terminates when an epoch has zero errors (converged) or after MAX_EPOCH epochs (timeout).
- Sits between the sample source (testbench or ROM sequencer) and the weight consumer or inference datapath.

Parameters:
N_IN, 2, number of inputs/weights (1..8)
DW, 7, signed input width
WW, 14, signed weight/bias width, fixed point with FRAC fraction bits
FRAC, 4, fraction bits dropped after each product
ALPHA, 3, learning rate, unsigned integer, fits in DW bits
MAX_EPOCH, 200, epoch limit
EW, 8, epoch counter width, must satisfy 2^EW > MAX_EPOCH

Ports:
Clk  in  1  clock
Rst  in  1  synchronous active-high reset
start  in  1  pulse; clears weights and begins training
s_valid  in  1  sample valid
s_ready  out  1  trainer can accept a sample
s_x  in  N_IN*DW  packed signed inputs, x[i] at [i*DW +: DW]
s_t  in  2  target: t[1]=1 means -1, else +1
s_last  in  1  marks final sample of the epoch
y  out  2  last computed output, 01=+1, 11=-1
w_out  out  N_IN*WW  packed current weights
b_out  out  WW  current bias
busy  out  1  training in progress
done  out  1  training finished; held until next start
converged  out  1  valid with done; 1 means zero-error epoch reached
epoch_cnt  out  EW  completed epochs
err_cnt  out  EW  mismatches in current epoch, saturating

Behaviour:
- Reset is synchronous and active-high on Rst, clock Clk. On reset every register and output is 0, except y=01. State goes to IDLE. Reset mid-epoch aborts with no residue.
- FSM states: IDLE, WAIT, CALC, UPD, EPOCH, DONE.
- IDLE/DONE: on start, clear all weights, bias, epoch_cnt and err_cnt; go to WAIT. In DONE, done and converged hold until start.
- WAIT: s_ready=1. A transfer occurs when s_valid&s_ready; latch x, t and last, then go to CALC. s_valid outside WAIT is ignored (s_ready=0).
- CALC: compute Yin = sum_i((sx(x[i]) * w[i]) >>> FRAC) + b.
  - Use full 2*WW-bit products with arithmetic shift (floor); keep the low WW bits of each term.
  - Sum modulo 2^WW.
  - Register y = (Yin>=0) ? +1 : -1. Go to UPD.
- UPD: on mismatch, w[i] += (t=+1 ? +1 : -1) * ALPHA * sx(x[i]) and b += ±ALPHA. err_cnt increments, saturating at all-ones. Then:
  - if last=0, go to WAIT;
  - else go to EPOCH.
- EPOCH: epoch_cnt++.
  - If err_cnt==0 (including the final sample's error), set converged=1, done=1 and go to DONE.
  - Else if epoch_cnt+1==MAX_EPOCH, set converged=0, done=1 and go to DONE.
  - Else clear err_cnt and go to WAIT.
- Latency: 3 cycles per sample (WAIT, CALC, UPD), +1 cycle per epoch boundary.
- busy=1 in WAIT, CALC, UPD and EPOCH.
- start while busy is ignored.
- start and Rst in the same cycle: Rst wins.
- w_out and b_out are live register values at all times. Consumers sample them on done.

Optional Feature:
PTRAIN_SAT_EN
- Defined: the sum and each weight/bias update saturate to [-2^(WW-1), 2^(WW-1)-1] instead of wrapping.
- Undefined: all arithmetic is two's-complement modulo 2^WW.

Decomposition:
- Package ptrain_pkg: state enum; target and y encodings (POS=2'b01, NEG=2'b11); sat_add function used under the macro.
- Sub-module ptrain_mac: combinational sum-of-products plus sign, parametrised by N_IN, DW, WW and FRAC. It is reused by the inference datapath.

Test Plan:
1. Reset then idle: y=01, w_out=0, b_out=0, done=0, s_ready=0. s_valid pulses in IDLE cause no state change.
2. start; one sample x=(1,1), t=+1, last=1 -> no update; done after the epoch with converged=1, epoch_cnt=1, weights still 0.
3. start; x=(5,0), t=-1, last=1 -> epoch 1 sets w0=-15, b=-3. Epoch 2: Yin=-8, y=-1 -> done, converged=1, epoch_cnt=2.
4. MAX_EPOCH=4; contradictory pair x=(1,0) t=+1 and x=(1,0) t=-1 -> done with converged=0, epoch_cnt=4.
5. Rst asserted in CALC mid-epoch 2 -> next cycle all outputs at reset values. A new start trains correctly from zero.
6. With PTRAIN_SAT_EN: WW=8, ALPHA=63, x=(63,0), t=+1 repeated after forcing y mismatch -> w0 clamps at 127, no wrap to negative. Without the macro the wrapped value is checked instead.
